// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE MAC sequencer: FSM states,
// control-word bit positions and precision encodings.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_BIAS  = 3'd2,
    ST_MAC   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Bit positions inside the PE cr_* control word
  localparam int CR_HOLD      = 1;
  localparam int CR_RELU      = 2;
  localparam int CR_FEEDBACK  = 5;
  localparam int CR_ZERO_SUM1 = 7;
  localparam int CR_BIAS      = 13;
  localparam int CR_SHIFT     = 14;

  typedef enum logic [1:0] {
    PREC_8B = 2'd0,
    PREC_4B = 2'd1,
    PREC_2B = 2'd2
  } prec_e;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Bundle between the layer controller (master) and the MAC sequencer (slave),
// including the control lines the sequencer drives into the PE.
interface pe_mac_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int CR_W  = 18
);
  logic             start;
  logic [CNT_W-1:0] cfg_num_macs;
  logic [CNT_W-1:0] cfg_num_outputs;
  logic             cfg_use_bias;
  logic             cfg_relu;
  logic [7:0]       cfg_shift;
  logic [1:0]       cfg_precision;
  logic             op_valid;
  logic             op_ready;
  logic             res_valid;
  logic             res_ready;
  logic             enable_mac;
  logic             clear_mac;
  logic [CR_W-1:0]  cr;
  logic [1:0]       PRECISION;
  logic [7:0]       shift_fixed_point;
  logic             busy;
  logic             done;

  modport master (
    output start, cfg_num_macs, cfg_num_outputs, cfg_use_bias, cfg_relu,
           cfg_shift, cfg_precision, op_valid, res_ready,
    input  op_ready, res_valid, enable_mac, clear_mac, cr, PRECISION,
           shift_fixed_point, busy, done
  );

  modport slave (
    input  start, cfg_num_macs, cfg_num_outputs, cfg_use_bias, cfg_relu,
           cfg_shift, cfg_precision, op_valid, res_ready,
    output op_ready, res_valid, enable_mac, clear_mac, cr, PRECISION,
           shift_fixed_point, busy, done
  );
endinterface

// File: rtl/pe_cr_encoder.sv
// Combinational map from sequencer state and latched config to the PE
// control word; the sequencer registers the result.
module pe_cr_encoder
  import pe_ctrl_pkg::*;
#(
  parameter int CR_W = 18
) (
  input  state_e          state_i,
  input  logic            relu_i,
  input  logic [7:0]      shift_i,
  output logic [CR_W-1:0] cr_o
);

  always_comb begin
    cr_o = '0;
    case (state_i)
      ST_BIAS: begin
        cr_o[CR_BIAS]      = 1'b1;
        cr_o[CR_ZERO_SUM1] = 1'b1;
      end
      ST_MAC:  cr_o[CR_FEEDBACK] = 1'b1;
      ST_OUT: begin
        cr_o[CR_HOLD]  = 1'b1;
        cr_o[CR_RELU]  = relu_i;
        cr_o[CR_SHIFT] = (shift_i != 8'd0);
      end
      default: cr_o = '0;
    endcase
  end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Drives one PE through clear / bias / MAC stream / result for each output
// neuron of a job. Control outputs are registered decodes of the next state.
module pe_mac_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CR_W  = 18
) (
  input  logic               clk,
  input  logic               reset,
  pe_mac_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mac_cnt_q, mac_cnt_d, out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] macs_q, macs_d, outs_q, outs_d;
  logic             use_bias_q, use_bias_d, relu_q, relu_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       prec_q, prec_d;
  logic             op_ready_q, res_valid_q, mac_en_q, clear_q, busy_q, done_q;
  logic [CR_W-1:0]  cr_q, cr_d;
  logic             op_hs, res_hs;

  assign op_hs  = op_ready_q & bus.op_valid;
  assign res_hs = res_valid_q & bus.res_ready;

  always_comb begin
    state_d    = state_q;
    mac_cnt_d  = mac_cnt_q;
    out_cnt_d  = out_cnt_q;
    macs_d     = macs_q;
    outs_d     = outs_q;
    use_bias_d = use_bias_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    prec_d     = prec_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          macs_d     = bus.cfg_num_macs;
          outs_d     = (bus.cfg_num_outputs == '0) ? CNT_W'(1) : bus.cfg_num_outputs;
          use_bias_d = bus.cfg_use_bias;
          relu_d     = bus.cfg_relu;
          shift_d    = bus.cfg_shift;
          prec_d     = bus.cfg_precision;
          out_cnt_d  = '0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mac_cnt_d = '0;
        if (use_bias_q)          state_d = ST_BIAS;
        else if (macs_q == '0)   state_d = ST_OUT;
        else                     state_d = ST_MAC;
      end
      ST_BIAS: state_d = (macs_q == '0) ? ST_OUT : ST_MAC;
      ST_MAC: begin
        if (op_hs) begin
          mac_cnt_d = mac_cnt_q + 1'b1;
          if (mac_cnt_d == macs_q) state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_hs) begin
          out_cnt_d = out_cnt_q + 1'b1;
          state_d   = (out_cnt_d == outs_q) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  pe_cr_encoder #(.CR_W(CR_W)) u_cr_enc (
    .state_i (state_d),
    .relu_i  (relu_d),
    .shift_i (shift_d),
    .cr_o    (cr_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mac_cnt_q  <= '0;
      out_cnt_q  <= '0;
      macs_q     <= '0;
      outs_q     <= '0;
      use_bias_q <= 1'b0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      prec_q     <= '0;
    end else begin
      state_q    <= state_d;
      mac_cnt_q  <= mac_cnt_d;
      out_cnt_q  <= out_cnt_d;
      macs_q     <= macs_d;
      outs_q     <= outs_d;
      use_bias_q <= use_bias_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      prec_q     <= prec_d;
    end
  end

  // Output registers follow state_d so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      mac_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cr_q        <= '0;
    end else begin
      op_ready_q  <= (state_d == ST_MAC);
      res_valid_q <= (state_d == ST_OUT);
      mac_en_q    <= (state_d == ST_CLEAR) || (state_d == ST_BIAS);
      clear_q     <= (state_d == ST_CLEAR);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      cr_q        <= cr_d;
    end
  end

  // MAC enable follows op_valid combinationally so stalls hold the accumulator
  assign bus.enable_mac        = mac_en_q | op_hs;
  assign bus.op_ready          = op_ready_q;
  assign bus.res_valid         = res_valid_q;
  assign bus.clear_mac         = clear_q;
  assign bus.cr                = cr_q;
  assign bus.PRECISION         = prec_q;
  assign bus.shift_fixed_point = shift_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

endmodule
